// File: rtl/micro_chk_pkg.sv
// Shared types and constants for the micro tile self-test checker.
package micro_chk_pkg;

  // Sequencer states, visited in order for one run
  typedef enum logic [2:0] {
    IDLE,
    PT,
    REL,
    CNT,
    FIN
  } state_e;

  // Phase codes recorded with the first mismatch
  localparam logic PH_PT  = 1'b0;
  localparam logic PH_CNT = 1'b1;

  // ui_in value driven once the tile is out of reset; the tile must ignore it
  localparam logic [7:0] REL_UI_VAL = 8'hFF;

  // Leading zero samples caused by the tile's internal reset synchroniser
  localparam int CNT_SYNC_ZEROS = 2;

  // Expected tile count at counter-phase sample j
  function automatic logic [7:0] cnt_expected(input logic [9:0] j);
    logic [9:0] shifted;
    shifted = j - 10'(CNT_SYNC_ZEROS - 1);
    if (j < 10'(CNT_SYNC_ZEROS)) begin
      cnt_expected = 8'h00;
    end else begin
      cnt_expected = shifted[7:0];
    end
  endfunction

endpackage

// File: rtl/micro_chk_scoreboard.sv
// Mismatch scoreboard: saturating error count plus capture of the first mismatch.
module micro_chk_scoreboard
  import micro_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       cmp_en,
  input  logic       phase,
  input  logic [7:0] exp,
  input  logic [7:0] act,
  output logic       mismatch,
  output logic [7:0] err_count,
  output logic       first_err_phase,
  output logic [7:0] first_err_exp,
  output logic [7:0] first_err_act
);

  logic [7:0] err_count_q, err_count_d;
  logic       first_phase_q, first_phase_d;
  logic [7:0] first_exp_q, first_exp_d;
  logic [7:0] first_act_q, first_act_d;

  // Count mismatches; a zero count means nothing has been captured yet this run
  always_comb begin
    mismatch      = cmp_en && (exp != act);
    err_count_d   = err_count_q;
    first_phase_d = first_phase_q;
    first_exp_d   = first_exp_q;
    first_act_d   = first_act_q;
    if (clear) begin
      err_count_d   = 8'h00;
      first_phase_d = 1'b0;
      first_exp_d   = 8'h00;
      first_act_d   = 8'h00;
    end else if (mismatch) begin
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'h01;
      end
      if (err_count_q == 8'h00) begin
        first_phase_d = phase;
        first_exp_d   = exp;
        first_act_d   = act;
      end
    end
  end

  // Scoreboard registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q   <= 8'h00;
      first_phase_q <= 1'b0;
      first_exp_q   <= 8'h00;
      first_act_q   <= 8'h00;
    end else begin
      err_count_q   <= err_count_d;
      first_phase_q <= first_phase_d;
      first_exp_q   <= first_exp_d;
      first_act_q   <= first_act_d;
    end
  end

  assign err_count       = err_count_q;
  assign first_err_phase = first_phase_q;
  assign first_err_exp   = first_exp_q;
  assign first_err_act   = first_act_q;

endmodule

// File: rtl/micro_tile_checker.sv
// Self-test sequencer wrapped around a micro test tile: checks reset
// pass-through, then the free-running counter after reset release.
module micro_tile_checker
  import micro_chk_pkg::*;
#(
  parameter int         PASS_LEN  = 16,
  parameter int         CNT_LEN   = 260,
  parameter logic [7:0] PASS_SEED = 8'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] tile_ui_in,
  output logic       tile_rst_n,
  input  logic [7:0] tile_uo_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       first_err_phase,
  output logic [7:0] first_err_exp,
  output logic [7:0] first_err_act
);

  state_e     state_q, state_d;
  logic [7:0] tile_ui_in_q, tile_ui_in_d;
  logic       tile_rst_n_q, tile_rst_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] k_q, k_d;
  logic [9:0] j_q, j_d;

  logic       sb_clear;
  logic       cmp_en;
  logic       cmp_phase;
  logic [7:0] cmp_exp;
  logic       sb_mismatch;
  logic [7:0] sb_err_count;

  // Next-state, pattern generation and expected-value selection
  always_comb begin
    state_d      = state_q;
    tile_ui_in_d = tile_ui_in_q;
    tile_rst_n_d = tile_rst_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    k_d          = k_q;
    j_d          = j_q;
    sb_clear     = 1'b0;
    cmp_en       = 1'b0;
    cmp_phase    = PH_PT;
    cmp_exp      = 8'h00;
    case (state_q)
      IDLE: begin
        tile_rst_n_d = 1'b0;
        if (start) begin
          sb_clear     = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          tile_ui_in_d = PASS_SEED;
          k_d          = 8'h00;
          state_d      = PT;
        end
      end
      PT: begin
        cmp_en       = 1'b1;
        cmp_phase    = PH_PT;
        cmp_exp      = tile_ui_in_q;
        k_d          = k_q + 8'h01;
        tile_ui_in_d = PASS_SEED + k_q + 8'h01;
        if (k_q == 8'(PASS_LEN - 1)) begin
          tile_rst_n_d = 1'b1;
          tile_ui_in_d = REL_UI_VAL;
          state_d      = REL;
        end
      end
      REL: begin
        j_d     = 10'd0;
        state_d = CNT;
      end
      CNT: begin
        cmp_en    = 1'b1;
        cmp_phase = PH_CNT;
        cmp_exp   = cnt_expected(j_q);
        j_d       = j_q + 10'd1;
        if (j_q == 10'(CNT_LEN - 1)) begin
          tile_rst_n_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          pass_d       = (sb_err_count == 8'h00) && !sb_mismatch;
          state_d      = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any run and holds the tile in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tile_ui_in_q <= 8'h00;
      tile_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      k_q          <= 8'h00;
      j_q          <= 10'd0;
    end else begin
      state_q      <= state_d;
      tile_ui_in_q <= tile_ui_in_d;
      tile_rst_n_q <= tile_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      k_q          <= k_d;
      j_q          <= j_d;
    end
  end

  micro_chk_scoreboard u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .clear           (sb_clear),
    .cmp_en          (cmp_en),
    .phase           (cmp_phase),
    .exp             (cmp_exp),
    .act             (tile_uo_out),
    .mismatch        (sb_mismatch),
    .err_count       (sb_err_count),
    .first_err_phase (first_err_phase),
    .first_err_exp   (first_err_exp),
    .first_err_act   (first_err_act)
  );

  assign tile_ui_in = tile_ui_in_q;
  assign tile_rst_n = tile_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = sb_err_count;

endmodule

// File: tb/tb_micro_tile_checker.sv
// Bench for micro_tile_checker: two builds (default and minimal lengths), each
// wrapped around a behavioural tile with injectable faults.
module tb_micro_tile_checker;

  localparam int         P1   = 16;
  localparam int         C1   = 260;
  localparam int         P2   = 1;
  localparam int         C2   = 2;
  localparam logic [7:0] SEED = 8'h3C;

  logic       clk;
  logic       rst;
  logic       start1, start2;
  logic [7:0] ui1, uo1, ec1, fe1, fa1;
  logic       rn1, busy1, done1, pass1, fp1;
  logic [7:0] ui2, uo2, ec2, fe2, fa2;
  logic       rn2, busy2, done2, pass2, fp2;

  logic [7:0] mask1 = 8'hFF;
  logic [7:0] mask2 = 8'hFF;
  logic       early1 = 1'b0;
  logic       early2 = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, a2 = 1'b0, b2 = 1'b0;
  logic [7:0] cnt1 = 8'h00;
  logic [7:0] cnt2 = 8'h00;

  int num_checks = 0;
  int num_errors = 0;

  micro_tile_checker #(.PASS_LEN(P1), .CNT_LEN(C1), .PASS_SEED(SEED)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .tile_ui_in(ui1), .tile_rst_n(rn1),
    .tile_uo_out(uo1), .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_err_phase(fp1), .first_err_exp(fe1), .first_err_act(fa1)
  );

  micro_tile_checker #(.PASS_LEN(P2), .CNT_LEN(C2), .PASS_SEED(SEED)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tile_ui_in(ui2), .tile_rst_n(rn2),
    .tile_uo_out(uo2), .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2),
    .first_err_phase(fp2), .first_err_exp(fe2), .first_err_act(fa2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile models: two-flop reset synchroniser normally, one flop when "early"
  always @(posedge clk) begin
    a1 <= rn1;
    b1 <= a1;
    if (early1 ? !a1 : !b1) cnt1 <= 8'h00;
    else cnt1 <= cnt1 + 8'h01;
    a2 <= rn2;
    b2 <= a2;
    if (early2 ? !a2 : !b2) cnt2 <= 8'h00;
    else cnt2 <= cnt2 + 8'h01;
  end

  assign uo1 = rn1 ? cnt1 : (ui1 & mask1);
  assign uo2 = rn2 ? cnt2 : (ui2 & mask2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input bit s, output logic b, output logic d, output logic p,
                      output logic rn, output logic fp, output logic [7:0] ui,
                      output logic [7:0] ec, output logic [7:0] fe, output logic [7:0] fa);
    b  = s ? busy2 : busy1;
    d  = s ? done2 : done1;
    p  = s ? pass2 : pass1;
    rn = s ? rn2 : rn1;
    fp = s ? fp2 : fp1;
    ui = s ? ui2 : ui1;
    ec = s ? ec2 : ec1;
    fe = s ? fe2 : fe1;
    fa = s ? fa2 : fa1;
  endtask

  // Reference: walk every sample of a run, derive what the tile returns, tally mismatches
  task automatic ref_model(input int plen, input int clen, input logic [7:0] mask,
                           input bit early, output int raw, output logic [7:0] ecnt,
                           output logic eph, output logic [7:0] eexp, output logic [7:0] eact);
    logic [7:0] e, a;
    raw = 0; eph = 1'b0; eexp = 8'h00; eact = 8'h00;
    for (int i = 0; i < plen; i++) begin
      e = SEED + 8'(i);
      a = e & mask;
      if (a != e) begin
        if (raw == 0) begin eph = 1'b0; eexp = e; eact = a; end
        raw++;
      end
    end
    for (int j = 0; j < clen; j++) begin
      e = (j < 2) ? 8'h00 : 8'(j - 1);
      a = early ? 8'(j) : e;
      if (a != e) begin
        if (raw == 0) begin eph = 1'b1; eexp = e; eact = a; end
        raw++;
      end
    end
    ecnt = (raw > 255) ? 8'hFF : 8'(raw);
  endtask

  // One full run on the selected build, with an optional ignored mid-run start pulse
  task automatic run_case(input string name, input bit s, input logic [7:0] mask,
                          input bit early, input int mid_start);
    int plen, clen, raw, cycles, bad;
    logic [7:0] ecnt, eexp, eact, xui, ui, ec, fe, fa;
    logic eph, xrn, b, d, p, rn, fp;
    plen = s ? P2 : P1;
    clen = s ? C2 : C1;
    if (s) begin mask2 = mask; early2 = early; end
    else begin mask1 = mask; early1 = early; end
    ref_model(plen, clen, mask, early, raw, ecnt, eph, eexp, eact);
    if (s) start2 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start2 = 1'b0;
    peek(s, b, d, p, rn, fp, ui, ec, fe, fa);
    num_checks++;
    if ({b, d} !== 2'b10) begin num_errors++; $display("[TB] FAIL %s.start busy,done: got %b%b expected 10", name, b, d); end
    cycles = 0; bad = 0;
    while (b === 1'b1 && cycles < 5000) begin
      xui = (cycles < plen) ? SEED + 8'(cycles) : 8'hFF;
      xrn = (cycles >= plen);
      if (ui !== xui || rn !== xrn) bad++;
      if (s) start2 = (cycles == mid_start); else start1 = (cycles == mid_start);
      cycles++;
      tick();
      peek(s, b, d, p, rn, fp, ui, ec, fe, fa);
    end
    start1 = 1'b0; start2 = 1'b0;
    num_checks++;
    if (cycles !== plen + 1 + clen) begin num_errors++; $display("[TB] FAIL %s.busy_cycles: got %0d expected %0d", name, cycles, plen + 1 + clen); end
    num_checks++;
    if (bad !== 0) begin num_errors++; $display("[TB] FAIL %s.tile_drive: got %0d bad cycles expected 0", name, bad); end
    num_checks++;
    if ({d, rn} !== 2'b10) begin num_errors++; $display("[TB] FAIL %s.done,rst_n: got %b%b expected 10", name, d, rn); end
    num_checks++;
    if (p !== (raw == 0)) begin num_errors++; $display("[TB] FAIL %s.pass: got %b expected %b", name, p, (raw == 0)); end
    num_checks++;
    if (ec !== ecnt) begin num_errors++; $display("[TB] FAIL %s.err_count: got %0d expected %0d", name, ec, ecnt); end
    num_checks++;
    if ({fp, fe, fa} !== {eph, eexp, eact}) begin
      num_errors++;
      $display("[TB] FAIL %s.first_err: got ph=%b exp=%h act=%h expected ph=%b exp=%h act=%h", name, fp, fe, fa, eph, eexp, eact);
    end
    tick();
  endtask

  task automatic test_reset();
    logic b, d, p, rn, fp;
    logic [7:0] ui, ec, fe, fa;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      peek(s[0], b, d, p, rn, fp, ui, ec, fe, fa);
      num_checks++;
      if ({b, d, p, rn, fp, ui, ec, fe, fa} !== 37'd0) begin
        num_errors++;
        $display("[TB] FAIL reset.dut%0d: got b=%b d=%b p=%b rn=%b fp=%b ui=%h ec=%h fe=%h fa=%h expected all 0", s + 1, b, d, p, rn, fp, ui, ec, fe, fa);
      end
    end
    rst = 1'b0;
    tick(); tick();
    peek(1'b0, b, d, p, rn, fp, ui, ec, fe, fa);
    num_checks++;
    if ({b, d, rn, ec} !== 11'd0) begin num_errors++; $display("[TB] FAIL idle_no_start: got b=%b d=%b rn=%b ec=%h expected 0", b, d, rn, ec); end
  endtask

  task automatic test_basic_runs();
    run_case("good", 1'b0, 8'hFF, 1'b0, -1);
    run_case("stuck_bit0", 1'b0, 8'hFE, 1'b0, -1);
    run_case("no_sync", 1'b0, 8'hFF, 1'b1, -1);
    run_case("good_after_fail", 1'b0, 8'hFF, 1'b0, -1);
  endtask

  task automatic test_rst_mid_run();
    logic b, d, p, rn, fp;
    logic [7:0] ui, ec, fe, fa;
    mask1 = 8'hFE; early1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (P1 + 1 + 50) tick();
    peek(1'b0, b, d, p, rn, fp, ui, ec, fe, fa);
    num_checks++;
    if ({b, ec} !== {1'b1, 8'd8}) begin num_errors++; $display("[TB] FAIL rst_mid.before: got busy=%b ec=%0d expected busy=1 ec=8", b, ec); end
    rst = 1'b1;
    tick();
    peek(1'b0, b, d, p, rn, fp, ui, ec, fe, fa);
    num_checks++;
    if ({b, d, p, rn, fp, ui, ec, fe, fa} !== 37'd0) begin
      num_errors++;
      $display("[TB] FAIL rst_mid.after: got b=%b d=%b p=%b rn=%b ui=%h ec=%h fe=%h fa=%h expected all 0", b, d, p, rn, ui, ec, fe, fa);
    end
    rst = 1'b0;
    tick();
    run_case("after_rst", 1'b0, 8'hFF, 1'b0, -1);
  endtask

  task automatic test_start_handling();
    logic b, d, p, rn, fp;
    logic [7:0] ui, ec, fe, fa;
    run_case("ignore_mid_start", 1'b0, 8'hFF, 1'b0, 100);
    repeat (3) tick();
    peek(1'b0, b, d, p, rn, fp, ui, ec, fe, fa);
    num_checks++;
    if ({b, d, p} !== 3'b011) begin num_errors++; $display("[TB] FAIL done_hold: got busy,done,pass=%b%b%b expected 011", b, d, p); end
    run_case("restart_after_done", 1'b0, 8'hFE, 1'b0, -1);
  endtask

  task automatic test_small_build();
    run_case("small_good", 1'b1, 8'hFF, 1'b0, -1);
    run_case("small_pt_fault", 1'b1, 8'h00, 1'b0, -1);
    run_case("small_no_sync", 1'b1, 8'hFF, 1'b1, -1);
  endtask

  task automatic test_random();
    logic [7:0] m;
    bit s, e;
    for (int it = 0; it < 6; it++) begin
      s = 1'($urandom_range(0, 1));
      m = 8'($urandom);
      if ($urandom_range(0, 2) == 0) m = 8'hFF;
      e = 1'($urandom_range(0, 1));
      run_case($sformatf("random%0d", it), s, m, e, int'($urandom_range(0, 300)));
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    test_reset();
    test_basic_runs();
    test_rst_mid_run();
    test_start_handling();
    test_small_build();
    test_random();
    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
